sensor_scan_controller: RTL and testbench

//  Sequences the parallel-in/serial-out sensor shift-register chain under the checkers board.

---
 rtl/sensor_scan_controller_if.sv | 26 ++
 rtl/sensor_scan_controller.sv | 174 +++++++++++++++++
 tb/tb_sensor_scan_controller.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_scan_controller_if.sv
// Change-event handshake between the board scanner and the game CPU.
// The scanner drives one square change per accepted valid/ready transfer.
interface sensor_scan_controller_if #(
   parameter int N_BITS = 32
);
   localparam int IW = $clog2(N_BITS);

   logic          evt_valid;
   logic          evt_ready;
   logic [IW-1:0] evt_index;
   logic          evt_value;

   modport master (
      output evt_valid,
      output evt_index,
      output evt_value,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_index,
      input  evt_value,
      output evt_ready
   );
endinterface

// File: rtl/sensor_scan_controller.sv
// Checkers-board PISO chain scanner with frame debounce and change events.
// Define SENSOR_INVERT_EN to invert sr_data for active-low hall sensors.
module sensor_scan_controller #(
   parameter int N_BITS          = 32,
   parameter int CLK_DIV         = 100,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int SCAN_GAP        = 256
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   output logic                   sr_clk,
   output logic                   sr_load_n,
   input  logic                   sr_data,
   output logic [N_BITS-1:0]      board_state,
   output logic                   board_valid,
   output logic                   frame_done,
   sensor_scan_controller_if.master evt
);

   localparam int IW   = $clog2(N_BITS);
   localparam int BW   = $clog2(N_BITS + 1);
   localparam int MW   = $clog2(DEBOUNCE_FRAMES + 1);
   localparam int CMAX = (2 * CLK_DIV > SCAN_GAP) ? 2 * CLK_DIV : SCAN_GAP;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [N_BITS-1:0] ONE = N_BITS'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_CAPTURE,
      S_EVENT,
      S_GAP
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]     cnt;
   logic [BW-1:0]     bit_cnt;
   logic [N_BITS-1:0] samp;
   logic [N_BITS-1:0] prev_frame;
   logic [N_BITS-1:0] pend;
   logic [N_BITS-1:0] pend_nxt;
   logic [N_BITS-1:0] diff;
   logic [MW-1:0]     match_cnt;
   logic [MW-1:0]     match_nxt;
   logic [IW-1:0]     idx;
   logic              sample_bit;
   logic              accept;
   logic              hs;
   logic              cnt_load_end;
   logic              cnt_half_end;
   logic              cnt_gap_end;
   logic              last_bit;

`ifdef SENSOR_INVERT_EN
   assign sample_bit = ~sr_data;
`else
   assign sample_bit = sr_data;
`endif

   assign cnt_load_end = (cnt == CW'(2 * CLK_DIV - 1));
   assign cnt_half_end = (cnt == CW'(CLK_DIV - 1));
   assign cnt_gap_end  = (({1'b0, cnt} + (CW+1)'(1)) >= (CW+1)'(SCAN_GAP));
   assign last_bit     = (bit_cnt == BW'(N_BITS));

   assign diff     = samp ^ board_state;
   assign pend_nxt = pend & (pend - ONE);
   assign accept   = (match_nxt >= MW'(DEBOUNCE_FRAMES));

   always_comb begin
      match_nxt = MW'(1);
      if (samp == prev_frame) begin
         if (match_cnt >= MW'(DEBOUNCE_FRAMES))
            match_nxt = MW'(DEBOUNCE_FRAMES);
         else
            match_nxt = match_cnt + MW'(1);
      end
   end

   // Lowest pending square first; pend only shrinks on a handshake.
   always_comb begin
      idx = '0;
      for (int i = N_BITS - 1; i >= 0; i--)
         if (pend[i]) idx = IW'(i);
   end

   assign sr_load_n     = (state != S_LOAD);
   assign frame_done    = (state == S_CAPTURE);
   assign evt.evt_valid = (state == S_EVENT);
   assign evt.evt_index = idx;
   assign evt.evt_value = evt.evt_valid & samp[idx];
   assign hs            = evt.evt_valid & evt.evt_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (enable) state_nxt = S_LOAD;
         S_LOAD:    if (cnt_load_end) state_nxt = S_SHIFT;
         S_SHIFT:   if (cnt_half_end && sr_clk && last_bit)
                       state_nxt = S_CAPTURE;
         S_CAPTURE: if (accept && board_valid && diff != '0)
                       state_nxt = S_EVENT;
                    else
                       state_nxt = S_GAP;
         S_EVENT:   if (hs && pend_nxt == '0) state_nxt = S_GAP;
         S_GAP:     if (cnt_gap_end) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt         <= '0;
         bit_cnt     <= '0;
         sr_clk      <= 1'b0;
         samp        <= '0;
         prev_frame  <= '0;
         match_cnt   <= '0;
         pend        <= '0;
         board_state <= '0;
         board_valid <= 1'b0;
      end else begin
         cnt <= '0;
         case (state)
            S_LOAD: begin
               bit_cnt <= '0;
               if (!cnt_load_end) cnt <= cnt + CW'(1);
            end
            S_SHIFT: begin
               if (cnt_half_end) begin
                  sr_clk <= ~sr_clk;
                  // Sample QH on the edge that raises sr_clk, before the chain shifts.
                  if (!sr_clk) begin
                     samp[bit_cnt[IW-1:0]] <= sample_bit;
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_CAPTURE: begin
               prev_frame <= samp;
               match_cnt  <= match_nxt;
               if (accept) begin
                  if (!board_valid) begin
                     board_state <= samp;
                     board_valid <= 1'b1;
                  end else begin
                     pend <= diff;
                  end
               end
            end
            S_EVENT: begin
               if (hs) begin
                  board_state[idx] <= samp[idx];
                  pend <= pend_nxt;
               end
            end
            S_GAP: begin
               if (!cnt_gap_end) cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_scan_controller.sv
// Bench for sensor_scan_controller: 74HC165-style chain model plus a
// frame-history reference that predicts the board image and event stream.
module tb_sensor_scan_controller;

   localparam int N  = 32;
   localparam int CD = 4;
   localparam int DB = 3;
   localparam int SG = 20;
`ifdef SENSOR_INVERT_EN
   localparam logic [N-1:0] INV = '1;
`else
   localparam logic [N-1:0] INV = '0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          sr_clk;
   logic          sr_load_n;
   logic          sr_data;
   logic [N-1:0]  board_state;
   logic          board_valid;
   logic          frame_done;

   sensor_scan_controller_if #(.N_BITS(N)) evt_if ();

   sensor_scan_controller #(
      .N_BITS(N),
      .CLK_DIV(CD),
      .DEBOUNCE_FRAMES(DB),
      .SCAN_GAP(SG)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .sr_clk(sr_clk),
      .sr_load_n(sr_load_n),
      .sr_data(sr_data),
      .board_state(board_state),
      .board_valid(board_valid),
      .frame_done(frame_done),
      .evt(evt_if)
   );

   always #5 clk = ~clk;

   logic [N-1:0] chain = '0;
   logic [N-1:0] sr_q  = '0;
   logic         sclk_d = 1'b0;

   always @(posedge clk) begin
      sclk_d <= sr_clk;
      if (!sr_load_n) sr_q <= chain;
      else if (sr_clk && !sclk_d) sr_q <= sr_q >> 1;
   end
   assign sr_data = sr_q[0];

   int rdy_mode = 0;
   initial begin
      evt_if.evt_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1:       evt_if.evt_ready = 1'b0;
            2:       evt_if.evt_ready = 1'b1;
            default: evt_if.evt_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [N-1:0] mboard = '0;
   bit           mvalid = 1'b0;
   logic [N-1:0] hist[$];
   int           eidx[$];
   bit           evalq[$];
   int           loadlen = 0;
   int           rise = 0;
   logic [N-1:0] ld_chain = '0;
   bit           sclk_p = 1'b0;
   bit           pv = 1'b0;
   bit           pr = 1'b0;
   logic [4:0]   pidx = '0;
   bit           pval = 1'b0;
   bit           rst_seen = 1'b0;

   // Accept a frame once the last DB frames since reset are all identical.
   task automatic model_frame(input logic [N-1:0] f);
      bit same;
      hist.push_back(f);
      if (hist.size() > DB) void'(hist.pop_front());
      same = (hist.size() == DB);
      foreach (hist[i]) if (hist[i] !== f) same = 1'b0;
      if (same) begin
         if (!mvalid) begin
            mboard = f;
            mvalid = 1'b1;
         end else begin
            for (int i = 0; i < N; i++)
               if (f[i] != mboard[i]) begin
                  eidx.push_back(i);
                  evalq.push_back(f[i]);
               end
            mboard = f;
         end
      end
   endtask

   always @(posedge clk) if (!reset_n) rst_seen = 1'b1;

   always @(negedge clk) begin
      if (rst_seen) begin
         rst_seen = 1'b0;
         hist.delete();
         eidx.delete();
         evalq.delete();
         mboard  = '0;
         mvalid  = 1'b0;
         loadlen = 0;
         rise    = 0;
      end else begin
         if (!sr_load_n) begin
            loadlen++;
            rise = 0;
            ld_chain = chain;
         end else if (loadlen != 0) begin
            chk("load_len", loadlen, 2 * CD);
            loadlen = 0;
         end
         if (sr_clk && !sclk_p) rise++;
         if (pv && !pr) begin
            chk("evt_hold_valid", evt_if.evt_valid, 1);
            chk("evt_hold_idx", evt_if.evt_index, pidx);
            chk("evt_hold_val", evt_if.evt_value, pval);
         end
         if (evt_if.evt_valid && evt_if.evt_ready) begin
            hs_cnt++;
            chk("evt_expected", eidx.size() != 0, 1);
            if (eidx.size() != 0) begin
               chk("evt_idx", evt_if.evt_index, eidx.pop_front());
               chk("evt_val", evt_if.evt_value, evalq.pop_front());
            end
         end
         if (frame_done) begin
            chk("sr_clk_rises", rise, N);
            chk("evt_drained", eidx.size(), 0);
            chk("board_state", board_state, mboard);
            chk("board_valid", board_valid, mvalid);
            model_frame(ld_chain ^ INV);
         end
      end
      sclk_p = sr_clk;
      pv     = evt_if.evt_valid;
      pr     = evt_if.evt_ready;
      pidx   = evt_if.evt_index;
      pval   = evt_if.evt_value;
   end

   task automatic run_frame(input logic [N-1:0] v);
      int n;
      chain = v;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 4000);
      chk("frame_seen", frame_done, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (evt_if.evt_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("evt_idle", evt_if.evt_valid, 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_sr_clk"}, sr_clk, 0);
      chk({tag, "_sr_load_n"}, sr_load_n, 1);
      chk({tag, "_board_state"}, board_state, 0);
      chk({tag, "_board_valid"}, board_valid, 0);
      chk({tag, "_evt_valid"}, evt_if.evt_valid, 0);
      chk({tag, "_evt_index"}, evt_if.evt_index, 0);
      chk({tag, "_evt_value"}, evt_if.evt_value, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
   endtask

   initial begin
      int h0;
      int n;
      logic [N-1:0] cur;
      logic [N-1:0] nv;

      reset_n = 1'b0;
      enable  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("rst");
      reset_n = 1'b1;
      enable  = 1'b1;

      h0 = hs_cnt;
      run_frame(32'h0000_0001 ^ INV);
      run_frame(32'h0000_0001 ^ INV);
      chk("t1_valid_early", board_valid, 0);
      run_frame(32'h0000_0001 ^ INV);
      chk("t1_valid", board_valid, 1);
      chk("t1_board", board_state, 32'h0000_0001);
      wait_idle();
      chk("t1_no_evt", hs_cnt - h0, 0);

      h0 = hs_cnt;
      repeat (DB) run_frame(32'h0000_0003 ^ INV);
      wait_idle();
      chk("t2_evt_cnt", hs_cnt - h0, 1);
      chk("t2_board", board_state, 32'h0000_0003);

      h0 = hs_cnt;
      run_frame(32'h8000_0003 ^ INV);
      repeat (DB) run_frame(32'h0000_0003 ^ INV);
      wait_idle();
      chk("t3_evt_cnt", hs_cnt - h0, 0);
      chk("t3_board", board_state, 32'h0000_0003);

      rdy_mode = 1;
      repeat (DB) run_frame(32'h0001_0002 ^ INV);
      chk("t4_valid_rise", evt_if.evt_valid, 1);
      repeat (20) begin
         @(negedge clk);
         chk("t4_hold_valid", evt_if.evt_valid, 1);
         chk("t4_hold_idx", evt_if.evt_index, 0);
         chk("t4_hold_val", evt_if.evt_value, 0);
      end
      rdy_mode = 2;
      @(negedge clk);
      chk("t4_e0_valid", evt_if.evt_valid, 1);
      chk("t4_e0_idx", evt_if.evt_index, 0);
      @(negedge clk);
      chk("t4_e1_valid", evt_if.evt_valid, 1);
      chk("t4_e1_idx", evt_if.evt_index, 16);
      chk("t4_e1_val", evt_if.evt_value, 1);
      @(negedge clk);
      chk("t4_evt_done", evt_if.evt_valid, 0);
      chk("t4_board", board_state, 32'h0001_0002);
      n = 0;
      while (sr_load_n && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("t4_gap_to_load", n, SG + 1);
      rdy_mode = 0;

      n = 0;
      while (!sr_load_n && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (100) @(negedge clk);
      chk("t5_mid_shift", sr_load_n, 1);
      chain = 32'h00F0_0F00 ^ INV;
      reset_n = 1'b0;
      @(negedge clk);
      chk_reset("t5");
      reset_n = 1'b1;
      @(negedge clk);
      chk("t5_fresh_load", sr_load_n, 0);
      run_frame(32'h00F0_0F00 ^ INV);
      run_frame(32'h00F0_0F00 ^ INV);
      chk("t5_valid_early", board_valid, 0);
      run_frame(32'h00F0_0F00 ^ INV);
      chk("t5_valid", board_valid, 1);
      chk("t5_board", board_state, 32'h00F0_0F00);

      n = 0;
      while (sr_load_n && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (50) @(negedge clk);
      enable = 1'b0;
      run_frame(32'h00F0_0F00 ^ INV);
      n = 0;
      repeat (400) begin
         @(negedge clk);
         if (!sr_load_n) n++;
      end
      chk("en_parked", n, 0);
      enable = 1'b1;

      cur = 32'h00F0_0F00;
      for (int k = 0; k < 8; k++) begin
         nv = cur ^ ($urandom & $urandom & $urandom);
         if (k % 2 == 1) run_frame($urandom ^ INV);
         repeat (DB) run_frame(nv ^ INV);
         wait_idle();
         chk("rnd_board", board_state, nv);
         cur = nv;
      end
      run_frame(cur ^ INV);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
